// File: rtl/lane_tick_sched.sv
// lane_tick_sched: central timing controller for the frog game traffic lanes.
// Owns the shared prescaler, the game-phase FSM (IDLE/RUN/PAUSE/OVER), the
// current level, and per-lane one-cycle step strobes whose periods shrink as
// the level rises.
//
// Ports:
//   i_Clk        system clock
//   i_Rst        synchronous active-high reset
//   i_start      level-sensitive start request (acts in IDLE and OVER)
//   i_level_up   one-cycle pulse, frog reached the far bank
//   i_hit        one-cycle pulse, collision detected
//   o_level      current level, 1..MAX_LEVEL
//   o_lane_step  per-lane registered one-cycle step strobes
//   o_state      00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   o_running    high only in RUN

// Per-lane step counter. One instance per lane, all sharing load/advance.
module lane_step_ctr (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       load,     // restart from the full period
    input  logic       adv,      // scheduler tick while staying in RUN
    input  logic [4:0] period,
    output logic       step
);
    logic [4:0] cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt  <= 5'd0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (load) begin
                cnt <= period;
            end else if (adv) begin
                // Counter at 1 on a tick means this tick completes the period.
                if (cnt == 5'd1) begin
                    cnt  <= period;
                    step <= 1'b1;
                end else begin
                    cnt <= cnt - 5'd1;
                end
            end
        end
    end
endmodule

module lane_tick_sched #(
    parameter int          NUM_LANES   = 4,
    parameter logic [24:0] PRESCALE    = 25'd1000000,
    parameter logic [4:0]  BASE_PERIOD = 5'd20,
    parameter logic [4:0]  PERIOD_STEP = 5'd1,
    parameter logic [4:0]  MIN_PERIOD  = 5'd2,
    parameter logic [4:0]  PAUSE_TICKS = 5'd16,
    parameter logic [6:0]  MAX_LEVEL   = 7'd16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_start,
    input  logic                 i_level_up,
    input  logic                 i_hit,
    output logic [6:0]           o_level,
    output logic [NUM_LANES-1:0] o_lane_step,
    output logic [1:0]           o_state,
    output logic                 o_running
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic [24:0] presc;
    logic [4:0]  pause_cnt;
    logic [6:0]  level;
    logic        running;
    logic        active, tick, enter_timed, lane_load, lane_adv;
    logic [6:0]  load_level;
    logic [NUM_LANES-1:0][4:0] lane_per;

    // Lane period: max(MIN, BASE - (lvl-1)*STEP + k), capped at 31.
    function automatic logic [4:0] lane_period(input logic [6:0] lvl, input int k);
        logic signed [11:0] p;
        p = $signed({7'd0, BASE_PERIOD})
          - $signed({5'd0, lvl - 7'd1}) * $signed({7'd0, PERIOD_STEP})
          + $signed(12'(k));
        if (p < $signed({7'd0, MIN_PERIOD})) p = $signed({7'd0, MIN_PERIOD});
        if (p > 12'sd31) p = 12'sd31;
        return p[4:0];
    endfunction

    assign active = (state == S_RUN) || (state == S_PAUSE);
    assign tick   = active && (presc == 25'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (i_hit) state_nxt = S_OVER;
                     else if (i_level_up) state_nxt = S_PAUSE;
            // Pause counter at 1 (or below) on a tick means it reaches 0 now.
            S_PAUSE: if (tick && pause_cnt <= 5'd1) state_nxt = S_RUN;
            S_OVER:  if (i_start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_timed = ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) && (state_nxt != state);
    assign lane_load   = (state_nxt == S_RUN) && (state != S_RUN);
    // A tick on the cycle RUN is left produces no steps.
    assign lane_adv    = (state == S_RUN) && (state_nxt == S_RUN) && tick;
    // Entering RUN from IDLE restarts at level 1; elsewhere the live level applies.
    assign load_level  = (state == S_IDLE) ? 7'd1 : level;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= S_IDLE;
            presc     <= PRESCALE - 25'd1;
            pause_cnt <= 5'd0;
            level     <= 7'd1;
            running   <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);

            if (enter_timed)
                presc <= PRESCALE - 25'd1;
            else if (active)
                presc <= (presc == 25'd0) ? PRESCALE - 25'd1 : presc - 25'd1;

            if (state == S_RUN && state_nxt == S_PAUSE)
                pause_cnt <= PAUSE_TICKS;
            else if (state == S_PAUSE && tick && pause_cnt != 5'd0)
                pause_cnt <= pause_cnt - 5'd1;

            if (state == S_IDLE && state_nxt == S_RUN)
                level <= 7'd1;
            else if (state == S_RUN && state_nxt == S_PAUSE)
                level <= (level >= MAX_LEVEL) ? MAX_LEVEL : level + 7'd1;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_per
        assign lane_per[g] = lane_period(load_level, g);
    end

    lane_step_ctr u_lane [NUM_LANES-1:0] (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .load   (lane_load),
        .adv    (lane_adv),
        .period (lane_per),
        .step   (o_lane_step)
    );

    assign o_level   = level;
    assign o_state   = state;
    assign o_running = running;
endmodule

// File: tb/tb_lane_tick_sched.sv
// Directed bench for lane_tick_sched with PRESCALE=4, BASE_PERIOD=5,
// PERIOD_STEP=1, MIN_PERIOD=2, PAUSE_TICKS=2, NUM_LANES=2, MAX_LEVEL=16.
// "RUN cycle c" is the c-th cycle with o_state=RUN, sampled 1 time unit
// after the rising edge that began it.
module tb_lane_tick_sched;
    localparam int NL = 2;
    localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_OVER = 2'b11;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_level_up = 1'b0;
    logic          i_hit = 1'b0;
    logic [6:0]    o_level;
    logic [NL-1:0] o_lane_step;
    logic [1:0]    o_state;
    logic          o_running;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    lane_tick_sched #(
        .NUM_LANES   (NL),
        .PRESCALE    (25'd4),
        .BASE_PERIOD (5'd5),
        .PERIOD_STEP (5'd1),
        .MIN_PERIOD  (5'd2),
        .PAUSE_TICKS (5'd2),
        .MAX_LEVEL   (7'd16)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_start     (i_start),
        .i_level_up  (i_level_up),
        .i_hit       (i_hit),
        .o_level     (o_level),
        .o_lane_step (o_lane_step),
        .o_state     (o_state),
        .o_running   (o_running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        tick();
        tick();
        i_Rst = 1'b0;
    endtask

    task automatic start_run(input string tag);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk({tag, "_entry"}, 32'(o_state), 32'(ST_RUN));
    endtask

    task automatic pulse_lu();
        i_level_up = 1'b1;
        tick();
        i_level_up = 1'b0;
    endtask

    // Expected strobe: first at cycle 'first', then every 'per'; first=0 means never.
    function automatic logic exp_step(input int c, input int first, input int per);
        return (first != 0) && (c >= first) && ((c - first) % per == 0);
    endfunction

    task automatic watch(input string tag, input int n, input int f0, input int p0,
                         input int f1, input int p1, input logic [1:0] st);
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s_c%0d_l0", tag, c), 32'(o_lane_step[0]), 32'(exp_step(c, f0, p0)));
            chk($sformatf("%s_c%0d_l1", tag, c), 32'(o_lane_step[1]), 32'(exp_step(c, f1, p1)));
            chk($sformatf("%s_c%0d_st", tag, c), 32'(o_state), 32'(st));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_state", 32'(o_state), 32'(ST_IDLE));
        chk("rst_level", 32'(o_level), 32'd1);
        chk("rst_step", 32'(o_lane_step), 32'd0);
        chk("rst_running", 32'(o_running), 32'd0);

        // 1: level 1 periods 5 and 6 ticks -> 20 and 24 cycles
        start_run("t1");
        chk("t1_running", 32'(o_running), 32'd1);
        chk("t1_level", 32'(o_level), 32'd1);
        watch("t1", 64, 21, 20, 25, 24, ST_RUN);

        // 2: level-up at RUN cycle 10, 8-cycle pause, then periods 4 and 5 ticks
        do_reset();
        start_run("t2");
        watch("t2a", 9, 21, 20, 25, 24, ST_RUN);
        pulse_lu();
        chk("t2_pause_state", 32'(o_state), 32'(ST_PAUSE));
        chk("t2_level", 32'(o_level), 32'd2);
        chk("t2_pause_running", 32'(o_running), 32'd0);
        watch("t2p", 8, 0, 1, 0, 1, ST_PAUSE);
        chk("t2_back_running", 32'(o_running), 32'd1);
        watch("t2b", 45, 17, 16, 21, 20, ST_RUN);

        // 3: six level-ups -> level 7, both lanes clamp to period 2; saturate at 16
        do_reset();
        start_run("t3");
        for (int i = 0; i < 6; i++) begin
            pulse_lu();
            repeat (8) tick();
        end
        chk("t3_level7", 32'(o_level), 32'd7);
        watch("t3", 24, 9, 8, 9, 8, ST_RUN);
        for (int i = 0; i < 12; i++) begin
            pulse_lu();
            repeat (8) tick();
        end
        chk("t3_level_sat", 32'(o_level), 32'd16);
        pulse_lu();
        chk("t3_sat_pause", 32'(o_state), 32'(ST_PAUSE));
        chk("t3_level_sat2", 32'(o_level), 32'd16);
        repeat (8) tick();
        watch("t3s", 10, 9, 8, 9, 8, ST_RUN);

        // 4: hit + level-up together -> OVER, level held, two-step restart
        do_reset();
        start_run("t4");
        pulse_lu();
        repeat (8) tick();
        chk("t4_level2", 32'(o_level), 32'd2);
        watch("t4a", 3, 17, 16, 21, 20, ST_RUN);
        i_hit = 1'b1;
        i_level_up = 1'b1;
        tick();
        i_hit = 1'b0;
        i_level_up = 1'b0;
        chk("t4_over_state", 32'(o_state), 32'(ST_OVER));
        chk("t4_over_level", 32'(o_level), 32'd2);
        chk("t4_over_running", 32'(o_running), 32'd0);
        watch("t4o", 30, 0, 1, 0, 1, ST_OVER);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t4_idle_state", 32'(o_state), 32'(ST_IDLE));
        watch("t4i", 5, 0, 1, 0, 1, ST_IDLE);
        start_run("t4r");
        chk("t4_restart_level", 32'(o_level), 32'd1);
        watch("t4r", 25, 21, 20, 25, 24, ST_RUN);

        // 5a: reset during PAUSE
        do_reset();
        start_run("t5p");
        pulse_lu();
        tick();
        tick();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk("t5p_state", 32'(o_state), 32'(ST_IDLE));
        chk("t5p_level", 32'(o_level), 32'd1);
        chk("t5p_step", 32'(o_lane_step), 32'd0);
        chk("t5p_running", 32'(o_running), 32'd0);

        // 5b: reset in RUN cycle 20, one cycle before lane 0's first strobe
        do_reset();
        start_run("t5r");
        watch("t5a", 19, 21, 20, 25, 24, ST_RUN);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk("t5r_step", 32'(o_lane_step), 32'd0);
        chk("t5r_state", 32'(o_state), 32'(ST_IDLE));
        chk("t5r_level", 32'(o_level), 32'd1);
        chk("t5r_running", 32'(o_running), 32'd0);
        watch("t5i", 10, 0, 1, 0, 1, ST_IDLE);

        // 6: hit and level-up pulses in PAUSE are ignored
        do_reset();
        start_run("t6");
        pulse_lu();
        tick();
        i_hit = 1'b1;
        tick();
        i_hit = 1'b0;
        chk("t6_hit_ignored", 32'(o_state), 32'(ST_PAUSE));
        pulse_lu();
        chk("t6_lu_ignored", 32'(o_level), 32'd2);
        watch("t6p", 5, 0, 1, 0, 1, ST_PAUSE);
        watch("t6r", 20, 17, 16, 21, 20, ST_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lane_tick_sched.md
Name: lane_tick_sched

Overview:
Central timing controller for the traffic lanes of the frog game. Owns the shared prescaler and the game-phase FSM (idle, run, level-up pause, game over), tracks the current level, and issues one-cycle step strobes per lane. Lane position blocks advance only on their strobe, so all lane speeds come from this block's level-dependent periods.

Parameters:
NUM_LANES, 4, number of lanes driven (1..8)
PRESCALE, 25'd1000000, i_Clk cycles per scheduler tick (>=2)
BASE_PERIOD, 5'd20, ticks between steps for lane 0 at level 1
PERIOD_STEP, 5'd1, period reduction per level above 1
MIN_PERIOD, 5'd2, floor on any lane period (>=1)
PAUSE_TICKS, 5'd16, ticks spent in PAUSE after a level-up
MAX_LEVEL, 7'd16, saturation value of o_level

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  synchronous active-high reset
i_start  in  1  level-sensitive start request; acts in IDLE and OVER
i_level_up  in  1  one-cycle pulse: frog reached the far bank
i_hit  in  1  one-cycle pulse: collision detected
o_level  out  7  current level, 1..MAX_LEVEL
o_lane_step  out  NUM_LANES  per-lane one-cycle step strobes
o_state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
o_running  out  1  high only in RUN

Behaviour:
- Reset (any cycle, including mid-RUN or mid-PAUSE): state IDLE, o_level=1, o_lane_step=0, o_running=0, prescaler=PRESCALE-1, lane counters=0, pause counter=0. Reset has priority over all inputs.
- Prescaler: runs only in RUN and PAUSE. Decrements each cycle. When it is 0 that cycle is a tick, and it reloads PRESCALE-1. It is set to PRESCALE-1 on every entry to RUN or PAUSE.
- Period: P = BASE_PERIOD - (o_level-1)*PERIOD_STEP, computed in 12-bit signed arithmetic. Lane k period = max(MIN_PERIOD, P + k), saturated to 5 bits (31).
- FSM transitions:
  - IDLE: if i_start=1, go to RUN, set o_level=1, and load every lane counter with its period.
  - RUN: if i_hit=1, go to OVER. Otherwise, if i_level_up=1, set o_level=min(o_level+1, MAX_LEVEL), go to PAUSE, and load the pause counter with PAUSE_TICKS. i_hit has priority when both pulses occur in the same cycle.
  - PAUSE: decrement the pause counter on each tick. On the tick where it reaches 0, go to RUN and reload lane counters using the new level. i_hit and i_level_up are ignored in PAUSE.
  - OVER: o_level holds its value. If i_start=1, go to IDLE. i_start must be seen again in IDLE before RUN begins (two-step restart).
- Lane stepping, RUN only: on a tick, each lane counter decrements. A lane whose counter is 1 at that tick reloads its period and sets its o_lane_step bit.
- o_lane_step is registered: high for exactly the one cycle after the tick edge, and 0 in every other state and cycle.
- Timing: the first step of lane k occurs period_k ticks after RUN entry, then every period_k ticks. Counters entering RUN from PAUSE restart from the full period; no partial carry-over.
- A tick and a transition in the same cycle: the transition wins. Leaving RUN suppresses that tick's steps.
- o_running and o_state are registered and reflect the current state.
- Latency: an i_start/i_level_up/i_hit sampled at edge N is visible on o_state after edge N.

Test Plan:
All scenarios use PRESCALE=4, BASE_PERIOD=5, PERIOD_STEP=1, MIN_PERIOD=2, PAUSE_TICKS=2, NUM_LANES=2, MAX_LEVEL=16.
1. Reset, then i_start pulse; count cycles in RUN from 1 -> lane0 strobe in cycles 21, 41, 61; lane1 strobe in cycles 25, 49; each strobe exactly 1 cycle wide; o_level=1.
2. In RUN, pulse i_level_up at RUN cycle 10 -> o_state=PAUSE next cycle; o_level=2; no strobes for 8 cycles; return to RUN; lane0 then strobes every 16 cycles and lane1 every 20.
3. Issue 6 level-ups -> o_level=7; P=-1, so both lanes clamp to period 2 (strobe every 8 cycles). Keep issuing level-ups -> o_level stops at 16.
4. Assert i_hit and i_level_up in the same cycle in RUN -> o_state=OVER; o_level unchanged; strobes stay 0. i_start -> IDLE; i_start -> RUN with o_level=1.
5. Assert i_Rst during PAUSE and during RUN one cycle before a scheduled strobe -> next cycle IDLE, o_level=1, o_lane_step=0, no strobe emitted.
6. Pulse i_hit while in PAUSE -> ignored; PAUSE completes and returns to RUN normally.
